instruction_encoder: RTL

//  Inverse of the decode-side immediate path: packs opcode/register/funct fields plus a 32-bit

---
 rtl/instruction_encoder_pkg.sv | 39 +++
 rtl/instruction_encoder_if.sv | 42 ++++
 rtl/instruction_encoder_imm_packer.sv | 57 +++++
 rtl/instruction_encoder.sv | 103 ++++++++++
 4 files changed

// File: rtl/instruction_encoder_pkg.sv
// Shared ISA definitions for the instruction encoder (the isa_defs set).
//   - INSTR_W        : instruction word width (32)
//   - fmt_e          : instruction format codes FMT_R..FMT_J (6 and 7 are illegal)
//   - OPC_*          : RV32I major opcode constants
//   - enc_word_t     : packed instruction word plus its error sideband
//   - sext_fits()    : true when imm[31:msb] are all equal, i.e. the value fits
//                      a signed field whose sign bit sits at position msb
package instruction_encoder_pkg;

   localparam int INSTR_W = 32;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_JAL    = 7'h6F;

   typedef struct packed {
      logic [INSTR_W-1:0] word;
      logic               err;
   } enc_word_t;

   function automatic logic sext_fits(logic [31:0] imm, int unsigned msb);
      logic [31:0] upper;
      upper = $signed(imm) >>> msb;
      return (upper == '0) || (upper == '1);
   endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Request/response bundle of the instruction encoder.
//   request : i_valid / o_ready, i_format, i_opcode, i_rd, i_rs1, i_rs2,
//             i_funct3, i_funct7, i_imm
//   response: o_valid / i_ready, o_instr, o_err, plus o_err_cnt status
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. A producer holding valid high keeps its payload stable until
// that edge; ready may depend combinationally on the opposite side's ready
// (o_ready includes the pop on the output side), never on the same side's valid.
// The "slave" modport is the encoder, "master" is the loader/consumer side.
interface instruction_encoder_if #(
   parameter int ERR_CNT_W = 8
);
   import instruction_encoder_pkg::*;

   logic                 i_valid;
   logic                 o_ready;
   logic [2:0]           i_format;
   logic [6:0]           i_opcode;
   logic [4:0]           i_rd;
   logic [4:0]           i_rs1;
   logic [4:0]           i_rs2;
   logic [2:0]           i_funct3;
   logic [6:0]           i_funct7;
   logic [31:0]          i_imm;
   logic                 o_valid;
   logic                 i_ready;
   logic [INSTR_W-1:0]   o_instr;
   logic                 o_err;
   logic [ERR_CNT_W-1:0] o_err_cnt;

   modport slave (
      input  i_valid, i_format, i_opcode, i_rd, i_rs1, i_rs2,
             i_funct3, i_funct7, i_imm, i_ready,
      output o_ready, o_valid, o_instr, o_err, o_err_cnt
   );

   modport master (
      output i_valid, i_format, i_opcode, i_rd, i_rs1, i_rs2,
             i_funct3, i_funct7, i_imm, i_ready,
      input  o_ready, o_valid, o_instr, o_err, o_err_cnt
   );
endinterface

// File: rtl/instruction_encoder_imm_packer.sv
// Combinational packer: register/funct fields plus a 32-bit immediate in,
// RV32I instruction word plus error flag out.
//   format_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i : fields
//   enc_o : {word, err}
// Illegal formats (6, 7) give word 0 with err set.
// Optional macro ENC_RANGE_CHECK_EN: immediates that do not fit their format
// give word 0 with err set; without it they are silently truncated.
module instruction_encoder_imm_packer
   import instruction_encoder_pkg::*;
(
   input  logic [2:0]  format_i,
   input  logic [6:0]  opcode_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [31:0] imm_i,
   output enc_word_t   enc_o
);

   logic imm_ok;

   always_comb begin
      enc_o = '0;
      case (format_i)
         FMT_R: enc_o.word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
         FMT_I: enc_o.word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
         FMT_S: enc_o.word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
         FMT_B: enc_o.word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                              imm_i[4:1], imm_i[11], opcode_i};
         FMT_U: enc_o.word = {imm_i[31:12], rd_i, opcode_i};
         FMT_J: enc_o.word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                              rd_i, opcode_i};
         default: enc_o.err = 1'b1;
      endcase

`ifdef ENC_RANGE_CHECK_EN
      // B and J offsets are halfword aligned, so bit 0 must also be clear.
      case (format_i)
         FMT_I, FMT_S: imm_ok = sext_fits(imm_i, 11);
         FMT_B:        imm_ok = sext_fits(imm_i, 12) && !imm_i[0];
         FMT_J:        imm_ok = sext_fits(imm_i, 20) && !imm_i[0];
         FMT_U:        imm_ok = (imm_i[11:0] == 12'd0);
         default:      imm_ok = 1'b1;
      endcase
`else
      imm_ok = 1'b1;
`endif

      if (enc_o.err || !imm_ok) begin
         enc_o.word = '0;
         enc_o.err  = 1'b1;
      end
   end

endmodule

// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: two-stage valid/ready pipeline between the boot
// loader and the instruction memory write port.
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   bus (slave)    : request fields in, encoded word + error sideband out,
//                    saturating count of flagged words popped
// Stage 1 registers the packed word on accept; the following edge always
// moves it into the output FIFO, so latency is two edges on an empty FIFO.
// Optional macro ENC_RANGE_CHECK_EN enables immediate range checking inside
// the packer.
module instruction_encoder
   import instruction_encoder_pkg::*;
#(
   parameter int OUT_DEPTH = 2,
   parameter int ERR_CNT_W = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   instruction_encoder_if.slave    bus
);

   localparam int PTR_W = $clog2(OUT_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   enc_word_t            packed_w;
   logic                 s1_valid_q, s1_valid_d;
   enc_word_t            s1_word_q, s1_word_d;
   enc_word_t            mem_q [OUT_DEPTH];
   enc_word_t            mem_d [OUT_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   enc_word_t            head;
   logic                 accept, push, pop;

   instruction_encoder_imm_packer u_packer (
      .format_i (bus.i_format),
      .opcode_i (bus.i_opcode),
      .rd_i     (bus.i_rd),
      .rs1_i    (bus.i_rs1),
      .rs2_i    (bus.i_rs2),
      .funct3_i (bus.i_funct3),
      .funct7_i (bus.i_funct7),
      .imm_i    (bus.i_imm),
      .enc_o    (packed_w)
   );

   assign head   = mem_q[rd_ptr_q];
   assign pop    = (count_q != '0) && bus.i_ready;
   assign push   = s1_valid_q;
   // Words already in flight (FIFO + stage 1) never exceed OUT_DEPTH, so the
   // unconditional stage-1 push can only meet a full FIFO when it also pops.
   assign bus.o_ready = ((count_q + CNT_W'(s1_valid_q)) < CNT_W'(OUT_DEPTH)) || pop;
   assign accept = bus.i_valid && bus.o_ready;

   assign bus.o_valid   = (count_q != '0);
   assign bus.o_instr   = bus.o_valid ? head.word : '0;
   assign bus.o_err     = bus.o_valid ? head.err  : 1'b0;
   assign bus.o_err_cnt = err_cnt_q;

   always_comb begin
      s1_valid_d = accept;
      s1_word_d  = accept ? packed_w : s1_word_q;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      err_cnt_d  = err_cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = s1_word_q;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (head.err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
         end
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_q <= 1'b0;
         s1_word_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         err_cnt_q  <= '0;
         for (int i = 0; i < OUT_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_word_q  <= s1_word_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         err_cnt_q  <= err_cnt_d;
         mem_q      <= mem_d;
      end
   end

endmodule
